// File: rtl/hex_scan_if.sv
// Write port of the hex display scan controller: valid/ready handshake
// carrying a digit index, a 4-bit hex value and a blank flag.
interface hex_scan_if #(
   parameter int AW = 2
);
   logic          wr_valid;
   logic          wr_ready;
   logic [AW-1:0] wr_addr;
   logic [3:0]    wr_data;
   logic          wr_blank;

   modport master (output wr_valid, output wr_addr, output wr_data, output wr_blank,
                   input  wr_ready);
   modport slave  (input  wr_valid, input  wr_addr, input  wr_data, input  wr_blank,
                   output wr_ready);
endinterface

// File: rtl/hex_scan_ctrl.sv
// Multiplexed common-anode 7-segment scan controller with a per-digit store.
// Define HEX_SCAN_LZS_EN to enable leading-zero suppression on the display.
//
// state | meaning
// ------+-----------------------------------------------------------
// INIT  | clear one store entry per cycle, write port closed
// GUARD | all anodes off for GUARD_CYC cycles before the next digit
// SHOW  | drive anode idx with its decoded segments for SCAN_DIV cycles
module hex_scan_ctrl #(
   parameter int NUM_DIGITS = 4,
   parameter int SCAN_DIV   = 50000,
   parameter int GUARD_CYC  = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   hex_scan_if.slave             wr,
   output logic [0:6]            seg,
   output logic [NUM_DIGITS-1:0] digit_en,
   output logic                  frame_tick
);
   localparam int AW   = $clog2(NUM_DIGITS);
   localparam int CMAX = (SCAN_DIV > GUARD_CYC) ? SCAN_DIV : GUARD_CYC;
   localparam int CW   = $clog2(CMAX + 1);
   localparam logic [CW-1:0] GUARD_LD = CW'(GUARD_CYC - 1);
   localparam logic [CW-1:0] SHOW_LD  = CW'(SCAN_DIV - 1);
   localparam logic [AW-1:0] LAST     = AW'(NUM_DIGITS - 1);

   typedef enum logic [1:0] {INIT, GUARD, SHOW} state_t;

   state_t        state, state_nx;
   logic [AW-1:0] idx, idx_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic [4:0]    store [NUM_DIGITS];
   logic [4:0]    sel;
   logic          sup;
   logic          addr_ok;

   function automatic logic [0:6] hex7(input logic [3:0] v);
      case (v)
         4'h0: hex7 = 7'h01;  4'h1: hex7 = 7'h4F;  4'h2: hex7 = 7'h12;  4'h3: hex7 = 7'h06;
         4'h4: hex7 = 7'h4C;  4'h5: hex7 = 7'h24;  4'h6: hex7 = 7'h20;  4'h7: hex7 = 7'h0F;
         4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h04;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h60;
         4'hC: hex7 = 7'h31;  4'hD: hex7 = 7'h42;  4'hE: hex7 = 7'h30;  default: hex7 = 7'h38;
      endcase
   endfunction

   always_comb begin
      state_nx = state;
      idx_nx   = idx;
      cnt_nx   = cnt;
      unique case (state)
         INIT: begin
            if (idx == LAST) begin
               state_nx = GUARD;
               idx_nx   = '0;
               cnt_nx   = GUARD_LD;
            end else begin
               idx_nx = idx + 1'b1;
            end
         end
         GUARD: begin
            if (cnt == '0) begin
               state_nx = SHOW;
               cnt_nx   = SHOW_LD;
            end else begin
               cnt_nx = cnt - 1'b1;
            end
         end
         SHOW: begin
            if (cnt == '0) begin
               state_nx = GUARD;
               cnt_nx   = GUARD_LD;
               idx_nx   = (idx == LAST) ? '0 : idx + 1'b1;
            end else begin
               cnt_nx = cnt - 1'b1;
            end
         end
         default: state_nx = INIT;
      endcase
   end

   // Address check only exists when the index field can encode missing digits.
   if ((2 ** AW) > NUM_DIGITS) begin : g_rng
      assign addr_ok = (wr.wr_addr <= LAST);
   end else begin : g_full
      assign addr_ok = 1'b1;
   end

`ifdef HEX_SCAN_LZS_EN
   logic [NUM_DIGITS-1:0] lead;

   // lead[k]: every digit above k is blank or zero
   always_comb begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
         lead[k] = 1'b1;
         for (int j = k + 1; j < NUM_DIGITS; j++)
            if (!store[j][4] && store[j][3:0] != 4'h0) lead[k] = 1'b0;
      end
   end

   always_comb begin
      sel = store[idx_nx];
      sup = sel[4];
      if (idx_nx != '0 && sel[3:0] == 4'h0 && lead[idx_nx]) sup = 1'b1;
   end
`else
   always_comb begin
      sel = store[idx_nx];
      sup = sel[4];
   end
`endif

   // Outputs are loaded from the next state so they change with the state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= INIT;
         idx      <= '0;
         cnt      <= '0;
         seg      <= 7'h7F;
         digit_en <= '1;
      end else begin
         state <= state_nx;
         idx   <= idx_nx;
         cnt   <= cnt_nx;
         if (state_nx == SHOW) begin
            seg      <= sup ? 7'h7F : hex7(sel[3:0]);
            digit_en <= ~(NUM_DIGITS'(1) << idx_nx);
         end else begin
            seg      <= 7'h7F;
            digit_en <= '1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         if (state == INIT)
            store[idx] <= 5'h10;
         else if (wr.wr_valid && wr.wr_ready && addr_ok)
            store[wr.wr_addr] <= {wr.wr_blank, wr.wr_data};
      end
   end

   assign wr.wr_ready = (state != INIT);
   assign frame_tick  = (state == SHOW) && (idx == LAST) && (cnt == '0);

endmodule
